if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_INC, default 4, byte increment between sequential fetches.
REQ-002 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port fetch_en_i  in  1  enables fetching from IDLE.
REQ-005 SHALL have port boot_addr_i  in  32  first fetch address after reset.
REQ-006 SHALL have port branch_i / branch_addr_i  in  1 / 32  redirect request and target.
REQ-007 SHALL have port instr_req_o / instr_addr_o  out  1 / 32  memory request and word address.
REQ-008 SHALL have port instr_gnt_i / instr_rvalid_i  in  1 / 1  memory grant and read-data valid.
REQ-009 SHALL have port capture_en_o  out  1  one-cycle pulse driving the fetch output register enable.
REQ-010 SHALL have port fetch_valid_o / fetch_pc_o  out  1 / 32  instruction available and its PC.
REQ-011 SHALL have port fetch_ready_i  in  1  downstream accepts the instruction.

Function
REQ-012 SHALL implement states IDLE, REQ, WAIT, VALID; only VALID asserts fetch_valid_o.
REQ-013 IDLE: when fetch_en_i=1, pc <= boot_addr_i with bits [1:0] cleared (first time only, else current pc); go to REQ.
REQ-014 REQ: instr_req_o=1, instr_addr_o=pc; on instr_gnt_i=1 go to WAIT.
REQ-015 WAIT: on instr_rvalid_i=1, capture_en_o SHALL pulse high for exactly the next cycle; state becomes VALID in that same next cycle.
REQ-016 Memory data SHALL be held stable from rvalid until the next grant; capture latency is 1 cycle after rvalid.
REQ-017 VALID: on fetch_ready_i=1, pc <= pc+PC_INC mod 2^32 (0xFFFFFFFC -> 0x00000000); go to REQ if fetch_en_i=1, else IDLE.
REQ-018 branch_i SHALL have priority over all sequential updates: pc <= branch_addr_i with [1:0] cleared, in any state except IDLE.
REQ-019 Branch in REQ without gnt: stay REQ, new address driven next cycle; with gnt same cycle: go WAIT, set discard flag.
REQ-020 Branch in WAIT: set discard flag; the outstanding response SHALL produce no capture_en_o pulse; on its rvalid go REQ.
REQ-021 Branch in VALID: drop fetch_valid_o next cycle, go REQ, ignore fetch_ready_i that cycle.
REQ-022 At most one request SHALL be outstanding; instr_req_o=0 outside REQ.

Reset
REQ-023 rst_i=1 SHALL immediately force state IDLE, pc=0, discard=0, all outputs 0, including mid-transaction; late rvalid after reset SHALL be ignored.

Configuration
REQ-024 Macro IF_FETCH_ERR_EN adds ports instr_err_i (in, 1) and fetch_err_o (out, 1).
REQ-025 With IF_FETCH_ERR_EN: instr_err_i sampled with rvalid; fetch_err_o=1 alongside fetch_valid_o; after acceptance go IDLE and remain until branch_i (branch_i from IDLE SHALL then be honoured).
REQ-026 Without IF_FETCH_ERR_EN: ports absent, no error tracking, behaviour per REQ-012..023.

Structure
REQ-027 Package if_pkg SHALL hold the state enum typedef, PC alignment mask constant and default PC_INC.
REQ-028 Sub-module if_pc_gen SHALL hold the pc register and next-pc mux (boot / branch / increment / hold).

Verification
REQ-029 Reset, boot_addr_i=0x80, fetch_en_i=1, gnt immediate, rvalid 1 cycle later -> instr_addr_o=0x80, capture pulse, fetch_pc_o=0x80, next addr 0x84.
REQ-030 gnt delayed 3 cycles, rvalid delayed 2 -> req held with stable address, single capture pulse, no second request.
REQ-031 branch_i to 0x203 during WAIT -> no capture for old response, next request 0x200, fetch_pc_o=0x200.
REQ-032 pc=0xFFFFFFFC accepted -> next instr_addr_o=0x00000000.
REQ-033 rst_i asserted in WAIT, rvalid arrives after release -> no capture, state IDLE, outputs 0.
REQ-034 IF_FETCH_ERR_EN, instr_err_i=1 with rvalid -> fetch_err_o=1 with valid; after ready no request until branch_i.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Build option IF_FETCH_ERR_EN (see if_fetch_ctrl) adds bus-error reporting.
package if_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWait  = 2'd2,
    StValid = 2'd3
  } if_state_e;

  typedef enum logic [1:0] {
    PcHold   = 2'd0,
    PcBoot   = 2'd1,
    PcBranch = 2'd2,
    PcInc    = 2'd3
  } pc_sel_e;

  localparam logic [31:0] PcAlignMask  = 32'hFFFF_FFFC;
  localparam int unsigned PcIncDefault = 4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PcAlignMask;
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Program counter register with boot / branch / increment / hold selection.
// Boot and branch targets are forced to word alignment.
module if_pc_gen
  import if_pkg::*;
#(
  parameter int unsigned PC_INC = PcIncDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  pc_sel_e     pc_sel_i,
  input  logic [31:0] boot_addr_i,
  input  logic [31:0] branch_addr_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    unique case (pc_sel_i)
      PcHold:   pc_d = pc_q;
      PcBoot:   pc_d = align_pc(boot_addr_i);
      PcBranch: pc_d = align_pc(branch_addr_i);
      // Wraps modulo 2^32 by construction.
      PcInc:    pc_d = pc_q + 32'(PC_INC);
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Single-outstanding instruction fetch controller (IDLE/REQ/WAIT/VALID).
// Define IF_FETCH_ERR_EN to add instr_err_i / fetch_err_o bus-error handling.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int unsigned PC_INC = PcIncDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  input  logic [31:0] boot_addr_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  output logic        capture_en_o,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_pc_o,
`ifdef IF_FETCH_ERR_EN
  input  logic        instr_err_i,
  output logic        fetch_err_o,
`endif
  input  logic        fetch_ready_i
);

  if_state_e   state_q, state_d;
  pc_sel_e     pc_sel;
  logic [31:0] pc;
  logic        discard_q, discard_d;
  logic        booted_q, booted_d;
  logic        capture_q, capture_d;
  logic        err_q;
  logic        halt_q;

`ifdef IF_FETCH_ERR_EN
  logic err_d, halt_d;
`else
  assign err_q  = 1'b0;
  assign halt_q = 1'b0;
`endif

  if_pc_gen #(
    .PC_INC(PC_INC)
  ) u_pc_gen (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pc_sel_i     (pc_sel),
    .boot_addr_i  (boot_addr_i),
    .branch_addr_i(branch_addr_i),
    .pc_o         (pc)
  );

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    booted_d  = booted_q;
    capture_d = 1'b0;
    pc_sel    = PcHold;
`ifdef IF_FETCH_ERR_EN
    err_d     = err_q;
    halt_d    = halt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (halt_q) begin
          // After an errored fetch only a redirect restarts the pipeline.
          if (branch_i) begin
            pc_sel  = PcBranch;
            state_d = StReq;
`ifdef IF_FETCH_ERR_EN
            halt_d  = 1'b0;
`endif
          end
        end else if (fetch_en_i) begin
          pc_sel   = booted_q ? PcHold : PcBoot;
          booted_d = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (branch_i) begin
          pc_sel = PcBranch;
          // Granted request was for the old address; drop its response.
          if (instr_gnt_i) begin
            state_d   = StWait;
            discard_d = 1'b1;
          end
        end else if (instr_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (branch_i) begin
          pc_sel = PcBranch;
        end
        if (instr_rvalid_i) begin
          if (discard_q || branch_i) begin
            state_d   = StReq;
            discard_d = 1'b0;
          end else begin
            state_d   = StValid;
            capture_d = 1'b1;
`ifdef IF_FETCH_ERR_EN
            err_d     = instr_err_i;
`endif
          end
        end else if (branch_i) begin
          discard_d = 1'b1;
        end
      end
      StValid: begin
        if (branch_i) begin
          pc_sel  = PcBranch;
          state_d = StReq;
`ifdef IF_FETCH_ERR_EN
          err_d   = 1'b0;
`endif
        end else if (fetch_ready_i) begin
          pc_sel = PcInc;
          if (err_q) begin
            state_d = StIdle;
`ifdef IF_FETCH_ERR_EN
            halt_d  = 1'b1;
            err_d   = 1'b0;
`endif
          end else begin
            state_d = fetch_en_i ? StReq : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      discard_q <= 1'b0;
      booted_q  <= 1'b0;
      capture_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      booted_q  <= booted_d;
      capture_q <= capture_d;
    end
  end

`ifdef IF_FETCH_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q  <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      halt_q <= halt_d;
    end
  end

  assign fetch_err_o = fetch_valid_o & err_q;
`endif

  // Outputs are gated by state so an idle controller presents all zeros.
  assign instr_req_o   = (state_q == StReq);
  assign instr_addr_o  = instr_req_o ? pc : '0;
  assign fetch_valid_o = (state_q == StValid);
  assign fetch_pc_o    = fetch_valid_o ? pc : '0;
  assign capture_en_o  = capture_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a memory responder checks request
// addresses and a monitor checks each capture pulse against queued PCs.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] boot_addr;
  logic        branch;
  logic [31:0] branch_addr;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        gnt;
  logic        rvalid;
  logic        capture_en;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
`ifdef IF_FETCH_ERR_EN
  logic        instr_err;
  logic        fetch_err;
  bit          err_resp = 1'b0;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] addr_q[$];
  logic [31:0] cap_q[$];
  int gnt_dly   = 0;
  int rv_dly    = 0;
  int grant_cnt = 0;
  bit manual    = 1'b1;

  if_fetch_ctrl #(
    .PC_INC(4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_en_i    (fetch_en),
    .boot_addr_i   (boot_addr),
    .branch_i      (branch),
    .branch_addr_i (branch_addr),
    .instr_req_o   (instr_req),
    .instr_addr_o  (instr_addr),
    .instr_gnt_i   (gnt),
    .instr_rvalid_i(rvalid),
    .capture_en_o  (capture_en),
    .fetch_valid_o (fetch_valid),
    .fetch_pc_o    (fetch_pc),
`ifdef IF_FETCH_ERR_EN
    .instr_err_i   (instr_err),
    .fetch_err_o   (fetch_err),
`endif
    .fetch_ready_i (fetch_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: grants after gnt_dly cycles, rvalid rv_dly cycles after the grant.
  initial begin : mem
    int g_cnt;
    int r_cnt;
    bit pend;
    logic [31:0] exp;
    g_cnt = 0;
    r_cnt = 0;
    pend  = 1'b0;
    forever begin
      @(negedge clk);
      if (manual || rst) begin
        g_cnt = 0;
        pend  = 1'b0;
        continue;
      end
      gnt    = 1'b0;
      rvalid = 1'b0;
`ifdef IF_FETCH_ERR_EN
      instr_err = 1'b0;
`endif
      if (pend) begin
        if (r_cnt == 0) begin
          rvalid = 1'b1;
`ifdef IF_FETCH_ERR_EN
          instr_err = err_resp;
`endif
          pend = 1'b0;
        end else begin
          r_cnt--;
        end
      end else if (instr_req) begin
        if (g_cnt >= gnt_dly) begin
          gnt = 1'b1;
          grant_cnt++;
          g_cnt = 0;
          pend  = 1'b1;
          r_cnt = rv_dly;
          n_vec++;
          if (addr_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_addr: unexpected request at %h, none required", instr_addr);
          end else begin
            exp = addr_q.pop_front();
            if (instr_addr !== exp) begin
              n_fail++;
              $display("FAIL req_addr: got %h, required %h", instr_addr, exp);
            end
          end
        end else begin
          g_cnt++;
        end
      end
    end
  end

  // Capture monitor: every capture pulse must match the next queued PC.
  initial begin : cap_mon
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && capture_en === 1'b1) begin
        n_vec++;
        if (cap_q.size() == 0) begin
          n_fail++;
          $display("FAIL capture: unexpected pulse pc=%h, none required", fetch_pc);
        end else begin
          exp = cap_q.pop_front();
          if (fetch_pc !== exp || fetch_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL capture: pc=%h valid=%b, required pc=%h valid=1",
                     fetch_pc, fetch_valid, exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] boot, input bit man);
    manual      = 1'b1;
    rst         = 1'b1;
    fetch_en    = 1'b0;
    branch      = 1'b0;
    branch_addr = '0;
    gnt         = 1'b0;
    rvalid      = 1'b0;
    fetch_ready = 1'b1;
    boot_addr   = boot;
`ifdef IF_FETCH_ERR_EN
    instr_err   = 1'b0;
    err_resp    = 1'b0;
`endif
    addr_q.delete();
    cap_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    manual = man;
  endtask

  task automatic run_until(input int budget, output bit ok);
    int n = 0;
    while (cap_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    ok = (cap_q.size() == 0);
  endtask

  task automatic stop_fetch();
    fetch_en = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    manual = 1'b1; rst = 1'b1; fetch_en = 1'b1; boot_addr = 32'h83;
    branch = 1'b0; branch_addr = '0; gnt = 1'b0; rvalid = 1'b0; fetch_ready = 1'b1;
    tick();
    tick();
    n_vec++;
    if (instr_req !== 1'b0 || instr_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_req: req=%b addr=%h, required 0/00000000", instr_req, instr_addr);
    end
    n_vec++;
    if (capture_en !== 1'b0 || fetch_valid !== 1'b0 || fetch_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_out: cap=%b valid=%b pc=%h, required 0/0/0",
               capture_en, fetch_valid, fetch_pc);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (instr_req !== 1'b1 || instr_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL boot_align: req=%b addr=%h, required 1/00000080", instr_req, instr_addr);
    end
    tick();
    n_vec++;
    if (instr_req !== 1'b1 || instr_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL req_hold: req=%b addr=%h, required 1/00000080", instr_req, instr_addr);
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset(32'h80, 1'b0);
    gnt_dly = 0; rv_dly = 0;
    addr_q = '{32'h80, 32'h84, 32'h88};
    cap_q  = '{32'h80, 32'h84, 32'h88};
    fetch_en = 1'b1;
    run_until(60, ok);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done: %0d captures pending, required 0", cap_q.size());
    end
    stop_fetch();
    n_vec++;
    if (instr_req !== 1'b0 || addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_idle: req=%b pending_addr=%0d, required 0/0", instr_req, addr_q.size());
    end
  endtask

  task automatic test_slow_mem();
    bit ok;
    int g0;
    int n = 0;
    int req_cycles = 0;
    do_reset(32'h1000, 1'b0);
    gnt_dly = 3; rv_dly = 2;
    addr_q = '{32'h1000, 32'h1004};
    cap_q  = '{32'h1000, 32'h1004};
    g0 = grant_cnt;
    fetch_en = 1'b1;
    while (grant_cnt == g0 && n < 20) begin
      tick();
      n++;
      if (instr_req === 1'b1) begin
        req_cycles++;
        n_vec++;
        if (instr_addr !== 32'h1000) begin
          n_fail++;
          $display("FAIL slow_stable: addr=%h, required 00001000", instr_addr);
        end
      end
    end
    n_vec++;
    if (req_cycles != 4) begin
      n_fail++;
      $display("FAIL slow_req_len: %0d request cycles, required 4", req_cycles);
    end
    run_until(80, ok);
    stop_fetch();
    n_vec++;
    if (!ok || grant_cnt - g0 != 2) begin
      n_fail++;
      $display("FAIL slow_grants: ok=%b grants=%0d, required 1/2", ok, grant_cnt - g0);
    end
  endtask

  task automatic test_branch(input bit in_wait);
    bit ok;
    int g0;
    int n = 0;
    do_reset(32'h100, 1'b0);
    gnt_dly = 0; rv_dly = 3;
    addr_q = '{32'h100, 32'h200, 32'h204};
    cap_q  = '{32'h200, 32'h204};
    g0 = grant_cnt;
    fetch_en = 1'b1;
    while (grant_cnt == g0 && n < 20) begin
      tick();
      n++;
    end
    if (in_wait) tick();
    branch = 1'b1;
    branch_addr = 32'h203;
    tick();
    branch = 1'b0;
    run_until(80, ok);
    stop_fetch();
    n_vec++;
    if (!ok || addr_q.size() != 0 || instr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_%s: ok=%b pending_addr=%0d req=%b, required 1/0/0",
               in_wait ? "wait" : "req_gnt", ok, addr_q.size(), instr_req);
    end
  endtask

  task automatic test_branch_req();
    bit ok;
    do_reset(32'h300, 1'b0);
    gnt_dly = 2; rv_dly = 0;
    addr_q = '{32'h400};
    cap_q  = '{32'h400};
    fetch_en = 1'b1;
    tick();
    branch = 1'b1;
    branch_addr = 32'h401;
    tick();
    branch = 1'b0;
    n_vec++;
    if (instr_req !== 1'b1 || instr_addr !== 32'h400) begin
      n_fail++;
      $display("FAIL branch_req_addr: req=%b addr=%h, required 1/00000400", instr_req, instr_addr);
    end
    run_until(40, ok);
    stop_fetch();
    n_vec++;
    if (!ok || addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL branch_req_done: ok=%b pending_addr=%0d, required 1/0", ok, addr_q.size());
    end
  endtask

  task automatic test_branch_valid();
    bit ok;
    int n = 0;
    do_reset(32'h500, 1'b0);
    gnt_dly = 0; rv_dly = 0;
    fetch_ready = 1'b0;
    addr_q = '{32'h500, 32'h600};
    cap_q  = '{32'h500, 32'h600};
    fetch_en = 1'b1;
    while (cap_q.size() > 1 && n < 30) begin
      tick();
      n++;
    end
    tick();
    n_vec++;
    if (capture_en !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== 32'h500) begin
      n_fail++;
      $display("FAIL stall_hold: cap=%b valid=%b pc=%h, required 0/1/00000500",
               capture_en, fetch_valid, fetch_pc);
    end
    branch = 1'b1;
    branch_addr = 32'h600;
    fetch_ready = 1'b1;
    tick();
    branch = 1'b0;
    n_vec++;
    if (fetch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_valid_drop: valid=%b, required 0", fetch_valid);
    end
    run_until(40, ok);
    stop_fetch();
    n_vec++;
    if (!ok || addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL branch_valid_done: ok=%b pending_addr=%0d, required 1/0", ok, addr_q.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset(32'hFFFF_FFFC, 1'b0);
    gnt_dly = 0; rv_dly = 1;
    addr_q = '{32'hFFFF_FFFC, 32'h0000_0000};
    cap_q  = '{32'hFFFF_FFFC, 32'h0000_0000};
    fetch_en = 1'b1;
    run_until(40, ok);
    stop_fetch();
    n_vec++;
    if (!ok || addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap: ok=%b pending_addr=%0d, required 1/0", ok, addr_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_reset(32'h40, 1'b1);
    fetch_en = 1'b1;
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if (instr_req !== 1'b0 || instr_addr !== 32'h0 || capture_en !== 1'b0 ||
        fetch_valid !== 1'b0 || fetch_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: req=%b addr=%h cap=%b valid=%b pc=%h, required all 0",
               instr_req, instr_addr, capture_en, fetch_valid, fetch_pc);
    end
    tick();
    rst = 1'b0;
    fetch_en = 1'b0;
    tick();
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    repeat (3) begin
      tick();
      if (instr_req !== 1'b0 || fetch_valid !== 1'b0 || capture_en !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL late_rvalid: %0d active cycles, required 0", bad);
    end
    fetch_en = 1'b1;
    tick();
    n_vec++;
    if (instr_req !== 1'b1 || instr_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL reset_reboot: req=%b addr=%h, required 1/00000040", instr_req, instr_addr);
    end
    fetch_en = 1'b0;
  endtask

`ifdef IF_FETCH_ERR_EN
  task automatic test_err();
    bit ok;
    int n = 0;
    int bad = 0;
    do_reset(32'h700, 1'b0);
    gnt_dly = 0; rv_dly = 0;
    err_resp = 1'b1;
    addr_q = '{32'h700};
    cap_q  = '{32'h700};
    fetch_en = 1'b1;
    while (cap_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    err_resp = 1'b0;
    n_vec++;
    if (fetch_err !== 1'b1 || fetch_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL err_flag: err=%b valid=%b, required 1/1", fetch_err, fetch_valid);
    end
    repeat (5) begin
      tick();
      if (instr_req !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL err_halt: %0d request cycles, required 0", bad);
    end
    addr_q = '{32'h800};
    cap_q  = '{32'h800};
    branch = 1'b1;
    branch_addr = 32'h802;
    tick();
    branch = 1'b0;
    n_vec++;
    if (instr_req !== 1'b1 || instr_addr !== 32'h800) begin
      n_fail++;
      $display("FAIL err_resume: req=%b addr=%h, required 1/00000800", instr_req, instr_addr);
    end
    run_until(40, ok);
    n_vec++;
    if (!ok || fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: ok=%b err=%b, required 1/0", ok, fetch_err);
    end
    stop_fetch();
  endtask
`endif

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    boot_addr = '0;
    branch = 1'b0;
    branch_addr = '0;
    gnt = 1'b0;
    rvalid = 1'b0;
    fetch_ready = 1'b1;
`ifdef IF_FETCH_ERR_EN
    instr_err = 1'b0;
`endif
    test_reset();
    test_basic();
    test_slow_mem();
    test_branch(1'b1);
    test_branch(1'b0);
    test_branch_req();
    test_branch_valid();
    test_wrap();
    test_reset_mid();
`ifdef IF_FETCH_ERR_EN
    test_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
